// File: rtl/shift_rotate_seq.sv
// shift_rotate_seq: multi-cycle shift/rotate unit, one bit-step per clock.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  operation request handshake (ready only in IDLE)
//   in_data/in_cnt  operand and number of bit-steps
//   in_op           000 SHL, 001 SHR, 010 ROL, 011 ROR, 100 SAR, 101 RCL, 110 RCR, 111 NOP
//   in_carry        initial carry
//   out_valid/ready result handshake
//   out_data/carry  result data and last bit moved
//   out_zero        out_data is all zeros (decoded from the data register)
//   busy            state is not IDLE
module shift_rotate_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [2:0]       in_op,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_SHL = 3'b000,
    OP_SHR = 3'b001,
    OP_ROL = 3'b010,
    OP_ROR = 3'b011,
    OP_SAR = 3'b100,
    OP_RCL = 3'b101,
    OP_RCR = 3'b110,
    OP_NOP = 3'b111
  } op_t;

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] data_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  // Single bit-step of the latched operation on the working registers.
  always_comb begin
    step_data  = data_q;
    step_carry = carry_q;
    case (op_q)
      OP_SHL: begin
        step_carry = data_q[WIDTH-1];
        step_data  = {data_q[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        step_carry = data_q[0];
        step_data  = {1'b0, data_q[WIDTH-1:1]};
      end
      OP_SAR: begin
        step_carry = data_q[0];
        step_data  = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      end
      OP_ROL: begin
        step_carry = data_q[WIDTH-1];
        step_data  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
      end
      OP_ROR: begin
        step_carry = data_q[0];
        step_data  = {data_q[0], data_q[WIDTH-1:1]};
      end
      OP_RCL: begin
        step_carry = data_q[WIDTH-1];
        step_data  = {data_q[WIDTH-2:0], carry_q};
      end
      OP_RCR: begin
        step_carry = data_q[0];
        step_data  = {carry_q, data_q[WIDTH-1:1]};
      end
      default: begin
        step_data  = data_q;
        step_carry = carry_q;
      end
    endcase
  end

  // State, working registers and registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_NOP;
      data_q    <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            carry_q <= in_carry;
            op_q    <= op_t'(in_op);
            cnt_q   <= in_cnt;
            busy    <= 1'b1;
            in_ready <= 1'b0;
            // Nothing to step: present the operand straight away.
            if (in_cnt == CNT_W'(0) || in_op == 3'b111) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q  <= step_data;
          carry_q <= step_carry;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_data  = data_q;
  assign out_carry = carry_q;
  assign out_zero  = (data_q == '0);

endmodule
